sat_divider: RTL and testbench

- Sequential signed saturating integer divider, the inverse companion of the team's combinational saturating multiplier.
- Computes quotient a_in / b_in, and optionally the remainder, in two's complement over DATA_WIDTH bits.
- Results that cannot be represented saturate to the format limits, as the multiplier does.
- Uses one radix-2 restoring iteration per clock, with valid/ready handshakes on both input and output. It sits in the arithmetic datapath wherever a normalise/scale-by-divide is required.

---
 rtl/sat_divider.sv | 160 ++++++++++++++++
 tb/tb_sat_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sat_divider.sv
// sat_divider: sequential signed saturating divider, one restoring step per clock.
// Optional feature macro: SAT_DIVIDER_REM_EN builds the remainder output register;
// without it rem_o is tied to zero (quotient, flags and timing unchanged).
module sat_divider #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic                  sat_o,
    output logic                  dz_o
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_dvd;      // dividend magnitude, shifted out MSB first
    logic [W:0]      r_abs_b;    // divisor magnitude
    logic [W-1:0]    r_prem;     // partial remainder magnitude
    logic [W-1:0]    r_quo;      // quotient magnitude, shifted in LSB
    logic            r_neg_q;
    logic            r_neg_a;
    logic            r_dz;
    logic            r_ovf;
    logic            r_valid;
    logic [W-1:0]    r_res;
    logic            r_sat;
    logic            r_dzf;

    logic [W-1:0]    w_abs_a;
    logic [W:0]      w_abs_b;
    logic [W:0]      w_trial;
    logic            w_ge;
    logic [W-1:0]    w_prem_nxt;
    logic [W-1:0]    w_q_signed;

    // Operand magnitudes; |MIN| fits a W-bit unsigned value
    assign w_abs_a = a_in[W-1] ? W'(-a_in) : a_in;
    assign w_abs_b = {1'b0, (b_in[W-1] ? W'(-b_in) : b_in)};

    // One restoring step: shift in next dividend bit, subtract if it fits
    assign w_trial    = {r_prem, r_dvd[W-1]};
    assign w_ge       = (w_trial >= r_abs_b);
    assign w_prem_nxt = w_ge ? W'(w_trial - r_abs_b) : w_trial[W-1:0];

    assign w_q_signed = r_neg_q ? W'(-r_quo) : r_quo;

    // Idle indication depends only on state and reset
    assign ready_o = (r_state == S_IDLE) && !rst_i;
    assign valid_o = r_valid;
    assign res_o   = r_res;
    assign sat_o   = r_sat;
    assign dz_o    = r_dzf;

`ifdef SAT_DIVIDER_REM_EN
    logic [W-1:0] r_rem;
    logic [W-1:0] w_rem_signed;

    // Remainder takes the dividend's sign; with b=0 the partial remainder ends as |a|
    assign w_rem_signed = r_neg_a ? W'(-r_prem) : r_prem;
    assign rem_o        = r_rem;

    // Remainder output register, loaded with the other results
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rem <= '0;
        end else if (r_state == S_DONE && !r_valid) begin
            r_rem <= r_ovf ? '0 : w_rem_signed;
        end
    end
`else
    assign rem_o = '0;
`endif

    // Control FSM and datapath: accept, iterate, present result until consumed
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_abs_b <= '0;
            r_prem  <= '0;
            r_quo   <= '0;
            r_neg_q <= 1'b0;
            r_neg_a <= 1'b0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_res   <= '0;
            r_sat   <= 1'b0;
            r_dzf   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_dvd   <= w_abs_a;
                        r_abs_b <= w_abs_b;
                        r_prem  <= '0;
                        r_quo   <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= a_in[W-1] ^ b_in[W-1];
                        r_neg_a <= a_in[W-1];
                        r_dz    <= (b_in == '0);
                        r_ovf   <= (a_in == MIN_VAL) && (b_in == '1);
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_prem <= w_prem_nxt;
                    r_dvd  <= {r_dvd[W-2:0], 1'b0};
                    r_quo  <= {r_quo[W-2:0], w_ge};
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W-1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        if (r_dz) begin
                            r_res <= r_neg_a ? MIN_VAL : MAX_VAL;
                            r_sat <= 1'b0;
                            r_dzf <= 1'b1;
                        end else if (r_ovf) begin
                            r_res <= MAX_VAL;
                            r_sat <= 1'b1;
                            r_dzf <= 1'b0;
                        end else begin
                            r_res <= w_q_signed;
                            r_sat <= 1'b0;
                            r_dzf <= 1'b0;
                        end
                    end else if (ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sat_divider.sv
// Bench for sat_divider: directed cases, random operands, backpressure and reset.
module tb_sat_divider;

    localparam int unsigned W = 16;
    localparam int MAXV = 32767;
    localparam int MINV = -32768;
`ifdef SAT_DIVIDER_REM_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] res_o;
    logic [W-1:0] rem_o;
    logic         sat_o;
    logic         dz_o;

    int tests = 0;
    int fails = 0;

    sat_divider #(.DATA_WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_in    (a_in),
        .b_in    (b_in),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .res_o   (res_o),
        .rem_o   (rem_o),
        .sat_o   (sat_o),
        .dz_o    (dz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with saturation rules
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output logic s, output logic d);
        s = 1'b0;
        d = 1'b0;
        if (b == 0) begin
            d = 1'b1;
            q = (a >= 0) ? MAXV : MINV;
            r = a;
        end else if (a == MINV && b == -1) begin
            s = 1'b1;
            q = MAXV;
            r = 0;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic do_op(input int a, input int b, input int bp_cycles, input bit hold_valid);
        int q;
        int r;
        logic s;
        logic d;
        int n;
        int seen;
        logic [W-1:0] exp_rem;
        model(a, b, q, r, s, d);
        exp_rem = REM_EN ? W'(r) : '0;
        n = 0;
        while (ready_o !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_accept", W'(ready_o), W'(1));
        valid_i = 1'b1;
        a_in    = W'(a);
        b_in    = W'(b);
        @(posedge clk); #1;
        if (!hold_valid) valid_i = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        check("busy_ready_low", W'(ready_o), W'(0));
        n = 0;
        while (valid_o !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
            a_in = W'($urandom);
            b_in = W'($urandom);
        end
        valid_i = 1'b0;
        check("latency", W'(n), W'(W + 1));
        check("res", res_o, W'(q));
        check("rem", rem_o, exp_rem);
        check("sat", W'(sat_o), W'(s));
        check("dz", W'(dz_o), W'(d));
        for (int i = 0; i < bp_cycles; i++) begin
            @(posedge clk); #1;
            check("bp_valid", W'(valid_o), W'(1));
            check("bp_res", res_o, W'(q));
            check("bp_rem", rem_o, exp_rem);
            check("bp_flags", W'({sat_o, dz_o}), W'({s, d}));
            check("bp_ready", W'(ready_o), W'(0));
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        check("consumed_valid", W'(valid_o), W'(0));
        check("idle_ready", W'(ready_o), W'(1));
        if (hold_valid) begin
            seen = 0;
            repeat (W + 4) begin
                @(posedge clk); #1;
                if (valid_o === 1'b1) seen++;
            end
            check("single_accept", W'(seen), W'(0));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [W-1:0] ra;
        logic signed [W-1:0] rb;
        int seen;

        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        a_in    = '0;
        b_in    = '0;
        #1;
        check("rst_ready", W'(ready_o), W'(0));
        check("rst_valid", W'(valid_o), W'(0));
        check("rst_res", res_o, W'(0));
        check("rst_rem", rem_o, W'(0));
        check("rst_flags", W'({sat_o, dz_o}), W'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        check("rel_ready", W'(ready_o), W'(1));

        do_op(100, 7, 5, 1'b0);
        do_op(-100, 7, 0, 1'b1);
        do_op(100, -7, 0, 1'b0);
        do_op(-100, -7, 0, 1'b0);
        do_op(MINV, -1, 2, 1'b0);
        do_op(MINV, 1, 0, 1'b0);
        do_op(1234, 0, 0, 1'b0);
        do_op(-5, 0, 0, 1'b0);
        do_op(MAXV, MINV, 0, 1'b0);
        do_op(MINV, MINV, 0, 1'b0);
        do_op(0, -3, 0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            ra = W'($urandom);
            if ((k % 3) == 0) rb = W'(int'($urandom_range(0, 20)) - 10);
            else              rb = W'($urandom);
            do_op(int'(ra), int'(rb), int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset in the middle of CALC discards the operation
        valid_i = 1'b1;
        a_in    = W'(1000);
        b_in    = W'(3);
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
        check("midrst_ready", W'(ready_o), W'(0));
        check("midrst_valid", W'(valid_o), W'(0));
        check("midrst_res", res_o, W'(0));
        @(posedge clk); #1;
        rst_i = 1'b0;
        #1;
        check("midrst_rel_ready", W'(ready_o), W'(1));
        seen = 0;
        repeat (W + 8) begin
            @(posedge clk); #1;
            if (valid_o === 1'b1) seen++;
        end
        check("midrst_no_emit", W'(seen), W'(0));
        do_op(50, 5, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
